// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - shared sizing constants and word/address types for the MIPS data memory
package datamem_pkg;

    localparam int DM_ADDR_WIDTH = 6;
    localparam int DM_DATA_WIDTH = 32;
    localparam int DM_DEPTH      = 2 ** DM_ADDR_WIDTH;

    typedef logic [DM_ADDR_WIDTH-1:0] dm_addr_t;
    typedef logic [DM_DATA_WIDTH-1:0] dm_word_t;

endpackage

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - falling-edge word array with enabled registered read
// Read and write in the same edge return the pre-write contents.
module data_memory_array
    import datamem_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  clearArray,
    input  logic                  clearData,
    input  logic                  writeEnable,
    input  logic                  readEnable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(negedge clock) begin
        if (clearArray) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (writeEnable) begin
            mem[address] <= writeData;
        end
    end

    // Sampling mem in the same edge as the write yields the old word.
    always_ff @(negedge clock) begin
        if (clearData) begin
            readData <= '0;
        end else if (readEnable) begin
            readData <= mem[address];
        end
    end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - MIPS data RAM top: reset priority and enable gating around the array
// Optional macro DATAMEM_RESET_CLEAR_EN: reset also zeroes every array word.
module data_memory
    import datamem_pkg::*;
#(
    parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemoryRead,
    input  logic                  MemoryWrite,
    output logic [DATA_WIDTH-1:0] ReadData
);

    logic clearArray;
    logic writeEnable;
    logic readEnable;

`ifdef DATAMEM_RESET_CLEAR_EN
    assign clearArray = Reset;
`else
    assign clearArray = 1'b0;
`endif

    // Reset wins over any access sampled at the same edge.
    assign writeEnable = MemoryWrite & ~Reset;
    assign readEnable  = MemoryRead  & ~Reset;

    data_memory_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clock      (Clock),
        .clearArray (clearArray),
        .clearData  (Reset),
        .writeEnable(writeEnable),
        .readEnable (readEnable),
        .address    (Address),
        .writeData  (WriteData),
        .readData   (ReadData)
    );

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory (honours DATAMEM_RESET_CLEAR_EN)
module tb_data_memory;
    import datamem_pkg::*;

    logic     Clock;
    logic     Reset;
    dm_addr_t Address;
    dm_word_t WriteData;
    logic     MemoryRead;
    logic     MemoryWrite;
    dm_word_t ReadData;

    int compared;
    int mismatched;

    dm_word_t model [DM_DEPTH];
    bit       known [DM_DEPTH];
    dm_word_t expRead;
    bit       expKnown;

    data_memory dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemoryRead (MemoryRead),
        .MemoryWrite(MemoryWrite),
        .ReadData   (ReadData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs applied just after a rising edge, sampled at the falling edge,
    // result observed just after the next rising edge.
    task automatic access(input logic rst, input logic rd, input logic wr,
                          input dm_addr_t a, input dm_word_t d);
        dm_word_t old;
        bit       oldKnown;
        Reset = rst; MemoryRead = rd; MemoryWrite = wr; Address = a; WriteData = d;
        @(posedge Clock);
        #1;
        if (rst) begin
            expRead  = '0;
            expKnown = 1'b1;
`ifdef DATAMEM_RESET_CLEAR_EN
            for (int i = 0; i < DM_DEPTH; i++) begin
                model[i] = '0;
                known[i] = 1'b1;
            end
`endif
        end else begin
            old      = model[a];
            oldKnown = known[a];
            if (wr) begin
                model[a] = d;
                known[a] = 1'b1;
            end
            if (rd) begin
                expRead  = old;
                expKnown = oldKnown;
            end
        end
    endtask

    task automatic test_reset();
        access(1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
        compared++;
        if (ReadData !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_readdata: got %h expected %h", ReadData, 32'h0);
        end
    endtask

    task automatic test_init();
        int       words [12] = '{0, 1, 2, 3, 4, 5, 8, 30, 32, 50, 51, 60};
        dm_word_t vals  [12] = '{32'd4, 32'd3, 32'd50, 32'd40, 32'd30, 32'd0, 32'd0,
                                 32'h132, 32'd16435934, 32'hAAAAFFFF, 32'd1431699200,
                                 32'hFFFF0000};
        for (int i = 0; i < 12; i++) begin
            access(1'b0, 1'b0, 1'b1, dm_addr_t'(words[i]), vals[i]);
        end
        compared++;
        if (ReadData !== 32'h0) begin
            mismatched++;
            $display("FAIL init_hold_zero: got %h expected %h", ReadData, 32'h0);
        end
    endtask

    task automatic test_reads();
        int       words [5] = '{5, 60, 51, 50, 3};
        dm_word_t vals  [5] = '{32'd0, 32'hFFFF0000, 32'd1431699200, 32'hAAAAFFFF, 32'd40};
        for (int i = 0; i < 5; i++) begin
            access(1'b0, 1'b1, 1'b0, dm_addr_t'(words[i]), 32'hFFFF0000);
            compared++;
            if (ReadData !== vals[i]) begin
                mismatched++;
                $display("FAIL read_word%0d: got %h expected %h", words[i], ReadData, vals[i]);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 1'b0, 1'b0, 6'd0, 32'hFFFF0000);
            compared++;
            if (ReadData !== 32'd40) begin
                mismatched++;
                $display("FAIL hold_edge%0d: got %h expected %h", i, ReadData, 32'd40);
            end
        end
    endtask

    task automatic test_read_write_same();
        access(1'b0, 1'b1, 1'b1, 6'd2, 32'd77);
        compared++;
        if (ReadData !== 32'd50) begin
            mismatched++;
            $display("FAIL rw_same_old: got %h expected %h", ReadData, 32'd50);
        end
        access(1'b0, 1'b1, 1'b0, 6'd2, 32'h0);
        compared++;
        if (ReadData !== 32'd77) begin
            mismatched++;
            $display("FAIL rw_same_new: got %h expected %h", ReadData, 32'd77);
        end
    endtask

    task automatic test_back_to_back();
        access(1'b0, 1'b0, 1'b1, 6'd40, 32'hDEADBEEF);
        access(1'b0, 1'b1, 1'b1, 6'd41, 32'h12345678);
        access(1'b0, 1'b1, 1'b0, 6'd40, 32'h0);
        compared++;
        if (ReadData !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL b2b_word40: got %h expected %h", ReadData, 32'hDEADBEEF);
        end
        access(1'b0, 1'b1, 1'b0, 6'd41, 32'h0);
        compared++;
        if (ReadData !== 32'h12345678) begin
            mismatched++;
            $display("FAIL b2b_word41: got %h expected %h", ReadData, 32'h12345678);
        end
    endtask

    task automatic test_reset_mid();
        dm_word_t exp1;
        dm_word_t exp60;
`ifdef DATAMEM_RESET_CLEAR_EN
        exp1  = 32'd0;
        exp60 = 32'd0;
`else
        exp1  = 32'd3;
        exp60 = 32'hFFFF0000;
`endif
        access(1'b0, 1'b1, 1'b0, 6'd60, 32'h0);
        access(1'b1, 1'b0, 1'b1, 6'd1, 32'd9);
        compared++;
        if (ReadData !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_mid_readdata: got %h expected %h", ReadData, 32'd0);
        end
        access(1'b0, 1'b1, 1'b0, 6'd1, 32'h0);
        compared++;
        if (ReadData !== exp1) begin
            mismatched++;
            $display("FAIL reset_mid_word1: got %h expected %h", ReadData, exp1);
        end
        access(1'b0, 1'b1, 1'b0, 6'd60, 32'h0);
        compared++;
        if (ReadData !== exp60) begin
            mismatched++;
            $display("FAIL reset_mid_word60: got %h expected %h", ReadData, exp60);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] byteAddr;
        dm_word_t    exp0;
`ifdef DATAMEM_RESET_CLEAR_EN
        exp0 = 32'd0;
`else
        exp0 = 32'd4;
`endif
        byteAddr = 32'h100;
        access(1'b0, 1'b1, 1'b0, byteAddr[7:2], 32'h0);
        compared++;
        if (ReadData !== exp0) begin
            mismatched++;
            $display("FAIL wrap_word0: got %h expected %h", ReadData, exp0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic     rst;
            logic     rd;
            logic     wr;
            dm_addr_t a;
            dm_word_t d;
            rst = ($urandom_range(0, 29) == 0);
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            a   = dm_addr_t'($urandom_range(0, DM_DEPTH - 1));
            d   = $urandom;
            access(rst, rd, wr, a, d);
            if (expKnown) begin
                compared++;
                if (ReadData !== expRead) begin
                    mismatched++;
                    $display("FAIL random_op%0d addr %0d: got %h expected %h", n, a, ReadData, expRead);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DM_DEPTH; i++) begin
            model[i] = '0;
            known[i] = 1'b0;
        end
        expRead     = '0;
        expKnown    = 1'b0;
        compared    = 0;
        mismatched  = 0;
        Reset       = 1'b1;
        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;
        Address     = '0;
        WriteData   = '0;
        @(posedge Clock);
        #1;
        test_reset();
        test_init();
        test_reads();
        test_hold();
        test_read_write_same();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
